tlb_sv39: RTL and testbench



---
 rtl/tlb_sv39.sv | 188 ++++++++++++++++++
 tb/tb_tlb_sv39.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_sv39.sv
// Fully-associative Sv39 TLB sitting in front of the page-table walker.
// Hits and bare-mode requests answer the cycle after acceptance. Misses issue one
// walk and answer the cycle after the walker's result. Walker leaves (4K/2M/1G)
// are installed unless a flush arrived while the walk was outstanding.
module tlb_sv39 #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] satp,
   input  logic        flush_all,
   input  logic        req_valid,
   input  logic [63:0] req_vaddr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [63:0] resp_paddr,
   output logic        resp_fault,
   output logic        ptw_req_valid,
   output logic [63:0] ptw_vaddr,
   input  logic        ptw_resp_valid,
   input  logic [43:0] ptw_resp_ppn,
   input  logic [1:0]  ptw_resp_level,
   input  logic        ptw_resp_fault
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   typedef enum logic [1:0] {StIdle, StWalk, StResp} state_t;

   state_t            state;
   logic              drop;
   logic [63:0]       last_satp;
   logic [IDX_W-1:0]  repl_ptr;

   logic [ENTRIES-1:0] ent_valid;
   logic [26:0]        ent_vpn   [ENTRIES];
   logic [43:0]        ent_ppn   [ENTRIES];
   logic [1:0]         ent_level [ENTRIES];

   logic              translate_on;
   logic              invalidate;
   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              has_free;
   logic [IDX_W-1:0]  free_idx;
   logic [IDX_W-1:0]  victim;
   logic              walk_bad;
   logic              install;

   // Superpage entries ignore the low VPN fields covered by the page offset.
   function automatic logic vpn_match(input logic [26:0] e_vpn, input logic [1:0] lvl,
                                      input logic [26:0] vpn);
      case (lvl)
         2'd1:    return e_vpn[26:9] == vpn[26:9];
         2'd2:    return e_vpn[26:18] == vpn[26:18];
         default: return e_vpn == vpn;
      endcase
   endfunction

   // Physical address: leaf PPN above the page offset, vaddr bits inside it.
   function automatic logic [55:0] compose(input logic [43:0] ppn, input logic [1:0] lvl,
                                           input logic [63:0] va);
      case (lvl)
         2'd1:    return {ppn[43:9], va[20:0]};
         2'd2:    return {ppn[43:18], va[29:0]};
         default: return {ppn, va[11:0]};
      endcase
   endfunction

   assign req_ready    = (state == StIdle);
   assign translate_on = (satp[63:60] == 4'h8);
   assign invalidate   = flush_all || (satp != last_satp);
   assign walk_bad     = ptw_resp_fault || (ptw_resp_level == 2'd3);
   // A flush coinciding with the walker result also suppresses the install.
   assign install      = (state == StWalk) && ptw_resp_valid && !walk_bad && !drop &&
                         !invalidate;
   assign victim       = has_free ? free_idx : repl_ptr;

   // Associative lookup; scanning downwards lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (ent_valid[i] && vpn_match(ent_vpn[i], ent_level[i], req_vaddr[38:12])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Lowest-index free slot, preferred over the round-robin pointer.
   always_comb begin
      has_free = 1'b0;
      free_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            has_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Entry array, replacement pointer and satp history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_valid <= '0;
         repl_ptr  <= '0;
         last_satp <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ent_vpn[i]   <= '0;
            ent_ppn[i]   <= '0;
            ent_level[i] <= '0;
         end
      end else begin
         last_satp <= satp;
         if (invalidate) begin
            ent_valid <= '0;
         end else if (install) begin
            ent_valid[victim] <= 1'b1;
            ent_vpn[victim]   <= ptw_vaddr[38:12];
            ent_ppn[victim]   <= ptw_resp_ppn;
            ent_level[victim] <= ptw_resp_level;
            if (!has_free) begin
               repl_ptr <= (repl_ptr == LAST_IDX) ? '0 : repl_ptr + IDX_W'(1);
            end
         end
      end
   end

   // Request FSM with registered response and walker-request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= StIdle;
         drop          <= 1'b0;
         resp_valid    <= 1'b0;
         resp_fault    <= 1'b0;
         resp_paddr    <= '0;
         ptw_req_valid <= 1'b0;
         ptw_vaddr     <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  ptw_vaddr <= req_vaddr;
                  if (!translate_on) begin
                     resp_paddr <= req_vaddr;
                     resp_valid <= 1'b1;
                     state      <= StResp;
                  end else if (hit && !invalidate) begin
                     resp_paddr <= {8'b0, compose(ent_ppn[hit_idx], ent_level[hit_idx],
                                                  req_vaddr)};
                     resp_valid <= 1'b1;
                     state      <= StResp;
                  end else begin
                     ptw_req_valid <= 1'b1;
                     state         <= StWalk;
                  end
               end
            end
            StWalk: begin
               if (ptw_resp_valid) begin
                  ptw_req_valid <= 1'b0;
                  resp_valid    <= 1'b1;
                  drop          <= 1'b0;
                  state         <= StResp;
                  if (walk_bad) begin
                     resp_fault <= 1'b1;
                     resp_paddr <= '0;
                  end else begin
                     resp_paddr <= {8'b0, compose(ptw_resp_ppn, ptw_resp_level, ptw_vaddr)};
                  end
               end else if (invalidate) begin
                  // Result still goes to the requester, but must not be cached.
                  drop <= 1'b1;
               end
            end
            StResp: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               state      <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_sv39.sv
// Bench for tlb_sv39: directed vector table, replacement and reset-mid-walk
// sequences, then random traffic against an abstract TLB model.
module tb_tlb_sv39;

   localparam int ENTRIES = 8;
   localparam logic [63:0] SATP_A = 64'h8000_0000_0008_0000;
   localparam logic [63:0] SATP_B = 64'h8000_0000_0009_0000;

   logic        clk;
   logic        rst;
   logic [63:0] satp;
   logic        flush_all;
   logic        req_valid;
   logic [63:0] req_vaddr;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_paddr;
   logic        resp_fault;
   logic        ptw_req_valid;
   logic [63:0] ptw_vaddr;
   logic        ptw_resp_valid;
   logic [43:0] ptw_resp_ppn;
   logic [1:0]  ptw_resp_level;
   logic        ptw_resp_fault;

   int tests = 0;
   int fails = 0;

   tlb_sv39 #(.ENTRIES(ENTRIES)) dut (
      .clk            (clk),
      .rst            (rst),
      .satp           (satp),
      .flush_all      (flush_all),
      .req_valid      (req_valid),
      .req_vaddr      (req_vaddr),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_paddr     (resp_paddr),
      .resp_fault     (resp_fault),
      .ptw_req_valid  (ptw_req_valid),
      .ptw_vaddr      (ptw_vaddr),
      .ptw_resp_valid (ptw_resp_valid),
      .ptw_resp_ppn   (ptw_resp_ppn),
      .ptw_resp_level (ptw_resp_level),
      .ptw_resp_fault (ptw_resp_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [63:0] satp;
      logic [63:0] va;
      logic        flush_now;
      logic        flush_mid;
      logic [43:0] wppn;
      logic [1:0]  wlvl;
      logic        wfault;
      logic        exp_walk;
      logic [63:0] exp_paddr;
      logic        exp_fault;
   } vec_t;

   function automatic vec_t mk(input logic [63:0] s, input logic [63:0] va, input logic fn,
                               input logic fm, input logic [43:0] wppn, input logic [1:0] wlvl,
                               input logic wf, input logic ew, input logic [63:0] ep,
                               input logic ef);
      vec_t v;
      v = '{s, va, fn, fm, wppn, wlvl, wf, ew, ep, ef};
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // One complete transaction starting and ending at a falling edge in IDLE.
   task automatic run_xact(input string tag, input logic [63:0] s, input logic [63:0] va,
                           input logic fn, input logic fm, input logic [43:0] wppn,
                           input logic [1:0] wlvl, input logic wf, input logic ew,
                           input logic [63:0] ep, input logic ef);
      check({tag, " ready"}, {63'b0, req_ready}, 64'd1);
      satp      = s;
      flush_all = fn;
      req_valid = 1'b1;
      req_vaddr = va;
      @(negedge clk);
      req_valid = 1'b0;
      flush_all = 1'b0;
      check({tag, " walk"}, {63'b0, ptw_req_valid}, {63'b0, ew});
      if (ew) begin
         check({tag, " ptw_vaddr"}, ptw_vaddr, va);
         check({tag, " early_resp"}, {62'b0, resp_valid, req_ready}, 64'd0);
         if (fm) begin
            flush_all = 1'b1;
            @(negedge clk);
            flush_all = 1'b0;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         check({tag, " walk_held"}, {63'b0, ptw_req_valid}, 64'd1);
         ptw_resp_valid = 1'b1;
         ptw_resp_ppn   = wppn;
         ptw_resp_level = wlvl;
         ptw_resp_fault = wf;
         @(negedge clk);
         ptw_resp_valid = 1'b0;
         ptw_resp_ppn   = '0;
         ptw_resp_level = '0;
         ptw_resp_fault = 1'b0;
         check({tag, " walk_dropped"}, {63'b0, ptw_req_valid}, 64'd0);
      end
      check({tag, " resp_valid"}, {63'b0, resp_valid}, 64'd1);
      check({tag, " paddr"}, resp_paddr, ep);
      check({tag, " fault"}, {63'b0, resp_fault}, {63'b0, ef});
      @(negedge clk);
      check({tag, " pulse_end"}, {61'b0, resp_valid, resp_fault, req_ready}, 64'd1);
   endtask

   task automatic do_reset();
      req_valid      = 1'b0;
      flush_all      = 1'b0;
      ptw_resp_valid = 1'b0;
      ptw_resp_ppn   = '0;
      ptw_resp_level = '0;
      ptw_resp_fault = 1'b0;
      rst            = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Abstract model: entries hold the request vaddr; paddr computed with masks.
   bit          m_valid [ENTRIES];
   logic [63:0] m_va    [ENTRIES];
   logic [43:0] m_ppn   [ENTRIES];
   int          m_lvl   [ENTRIES];
   int          m_ptr;
   logic [63:0] m_last;

   function automatic logic [63:0] m_paddr(input logic [43:0] ppn, input int lvl,
                                           input logic [63:0] va);
      logic [63:0] mask;
      mask = (64'd1 << (12 + 9 * lvl)) - 64'd1;
      return (({20'b0, ppn} << 12) & ~mask) | (va & mask);
   endfunction

   function automatic int m_lookup(input logic [63:0] va);
      int sh;
      for (int i = 0; i < ENTRIES; i++) begin
         sh = 12 + 9 * m_lvl[i];
         if (m_valid[i] && ((va[38:0] >> sh) == (m_va[i][38:0] >> sh))) return i;
      end
      return -1;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
   endtask

   task automatic m_install(input logic [63:0] va, input logic [43:0] ppn, input int lvl);
      int slot;
      slot = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
         slot  = m_ptr;
         m_ptr = (m_ptr + 1) % ENTRIES;
      end
      m_valid[slot] = 1'b1;
      m_va[slot]    = va;
      m_ppn[slot]   = ppn;
      m_lvl[slot]   = lvl;
   endtask

   vec_t        tbl [18];
   logic [63:0] base [16];

   initial begin
      satp      = '0;
      req_vaddr = '0;
      do_reset();

      check("reset_resp_valid", {63'b0, resp_valid}, 64'd0);
      check("reset_resp_fault", {63'b0, resp_fault}, 64'd0);
      check("reset_resp_paddr", resp_paddr, 64'd0);
      check("reset_ptw_req", {63'b0, ptw_req_valid}, 64'd0);
      check("reset_ptw_vaddr", ptw_vaddr, 64'd0);
      check("reset_ready", {63'b0, req_ready}, 64'd1);

      // ------------------------------------------------------------ directed table
      tbl[0]  = mk(64'd0,  64'h8000_1234,   0, 0, 44'h0,     2'd0, 0, 0, 64'h8000_1234, 0);
      tbl[1]  = mk(SATP_A, 64'h0040_2ABC,   0, 0, 44'h80123, 2'd0, 0, 1, 64'h8012_3ABC, 0);
      tbl[2]  = mk(SATP_A, 64'h0040_2ABC,   0, 0, 44'h0,     2'd0, 0, 0, 64'h8012_3ABC, 0);
      tbl[3]  = mk(SATP_A, 64'h4765_4321,   0, 0, 44'h80000, 2'd2, 0, 1, 64'h8765_4321, 0);
      tbl[4]  = mk(SATP_A, 64'h4000_0010,   0, 0, 44'h0,     2'd0, 0, 0, 64'h8000_0010, 0);
      tbl[5]  = mk(SATP_A, 64'h0030_0000,   0, 0, 44'h55555, 2'd0, 1, 1, 64'h0,         1);
      tbl[6]  = mk(SATP_A, 64'h0030_0000,   0, 0, 44'h12345, 2'd0, 0, 1, 64'h1234_5000, 0);
      tbl[7]  = mk(SATP_A, 64'h0050_0000,   0, 0, 44'h1,     2'd3, 0, 1, 64'h0,         1);
      tbl[8]  = mk(SATP_A, 64'h0060_0777,   0, 1, 44'h00ABC, 2'd0, 0, 1, 64'h00AB_C777, 0);
      tbl[9]  = mk(SATP_A, 64'h0060_0777,   0, 0, 44'h00ABC, 2'd0, 0, 1, 64'h00AB_C777, 0);
      tbl[10] = mk(SATP_A, 64'h0040_2ABC,   0, 0, 44'h80123, 2'd0, 0, 1, 64'h8012_3ABC, 0);
      tbl[11] = mk(SATP_B, 64'h0040_2ABC,   0, 0, 44'h80124, 2'd0, 0, 1, 64'h8012_4ABC, 0);
      tbl[12] = mk(SATP_B, 64'h0040_2ABC,   0, 0, 44'h0,     2'd0, 0, 0, 64'h8012_4ABC, 0);
      tbl[13] = mk(SATP_B, 64'h0040_2ABC,   1, 0, 44'h80125, 2'd0, 0, 1, 64'h8012_5ABC, 0);
      tbl[14] = mk(64'd0,  64'h1234_5678,   0, 0, 44'h0,     2'd0, 0, 0, 64'h1234_5678, 0);
      tbl[15] = mk(SATP_B, 64'h0040_2ABC,   0, 0, 44'h80126, 2'd0, 0, 1, 64'h8012_6ABC, 0);
      tbl[16] = mk(SATP_B, 64'h0080_1234,   0, 0, 44'h00200, 2'd1, 0, 1, 64'h0020_1234, 0);
      tbl[17] = mk(SATP_B, 64'h0099_9999,   0, 0, 44'h0,     2'd0, 0, 0, 64'h0039_9999, 0);

      for (int i = 0; i < 18; i++) begin
         run_xact($sformatf("vec%0d", i), tbl[i].satp, tbl[i].va, tbl[i].flush_now,
                  tbl[i].flush_mid, tbl[i].wppn, tbl[i].wlvl, tbl[i].wfault, tbl[i].exp_walk,
                  tbl[i].exp_paddr, tbl[i].exp_fault);
      end

      // ------------------------------------------------------------ replacement
      satp = SATP_A;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         run_xact($sformatf("fill%0d", i), SATP_A, 64'h1000_0010 + 64'(i) * 64'h1000, 0, 0,
                  44'h100 + 44'(i), 2'd0, 0, 1, ((64'h100 + 64'(i)) << 12) | 64'h10, 0);
      end
      for (int i = 1; i < 9; i++) begin
         run_xact($sformatf("refill_hit%0d", i), SATP_A, 64'h1000_0010 + 64'(i) * 64'h1000,
                  0, 0, 44'h0, 2'd0, 0, 0, ((64'h100 + 64'(i)) << 12) | 64'h10, 0);
      end
      run_xact("evicted_page0", SATP_A, 64'h1000_0010, 0, 0, 44'h200, 2'd0, 0, 1,
               64'h0020_0010, 0);

      // ------------------------------------------------------------ reset mid-walk
      req_valid = 1'b1;
      req_vaddr = 64'h2000_0000;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstwalk_started", {63'b0, ptw_req_valid}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rstwalk_async", {61'b0, ptw_req_valid, resp_valid, req_ready}, 64'd1);
      check("rstwalk_vaddr", ptw_vaddr, 64'd0);
      @(negedge clk);
      rst            = 1'b1;
      @(negedge clk);
      ptw_resp_valid = 1'b1;
      ptw_resp_ppn   = 44'hDEAD;
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      ptw_resp_ppn   = '0;
      check("stray_ignored", {62'b0, resp_valid, ptw_req_valid}, 64'd0);
      run_xact("post_reset_miss", SATP_A, 64'h1000_2010, 0, 0, 44'h300, 2'd0, 0, 1,
               64'h0030_0010, 0);

      // ------------------------------------------------------------ random vs model
      satp = SATP_A;
      do_reset();
      m_clear();
      m_ptr  = 0;
      m_last = 64'd0;
      for (int k = 0; k < 16; k++) base[k] = {$urandom(), $urandom()};
      for (int n = 0; n < 300; n++) begin
         logic [63:0] s, va, ep, xmask;
         logic [43:0] wppn;
         logic [1:0]  wlvl;
         logic        fn, fm, wf, ew, ef;
         int          idx;
         s = satp;
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
               0:       s = SATP_A;
               1:       s = SATP_B;
               default: s = 64'd0;
            endcase
         end
         case ($urandom_range(0, 2))
            0:       xmask = 64'h0000_0FFF;
            1:       xmask = 64'h001F_FFFF;
            default: xmask = 64'h3FFF_FFFF;
         endcase
         va   = base[$urandom_range(0, 15)] ^ ({$urandom(), $urandom()} & xmask);
         fn   = ($urandom_range(0, 15) == 0);
         fm   = 1'b0;
         wppn = {$urandom(), $urandom()};
         wlvl = 2'($urandom_range(0, 3));
         wf   = ($urandom_range(0, 7) == 0);
         ef   = 1'b0;
         if (fn || (s != m_last)) m_clear();
         m_last = s;
         if (s[63:60] != 4'h8) begin
            ew = 1'b0;
            ep = va;
         end else begin
            idx = m_lookup(va);
            if (idx >= 0) begin
               ew = 1'b0;
               ep = m_paddr(m_ppn[idx], m_lvl[idx], va);
            end else begin
               ew = 1'b1;
               fm = ($urandom_range(0, 15) == 0);
               ef = wf || (wlvl == 2'd3);
               ep = ef ? 64'd0 : m_paddr(wppn, int'(wlvl), va);
               if (fm) m_clear();
               else if (!ef) m_install(va, wppn, int'(wlvl));
            end
         end
         run_xact($sformatf("rand%0d", n), s, va, fn, fm, wppn, wlvl, wf, ew, ep, ef);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
